interleaver_input_ctrl: RTL and testbench

Frame-input controller for the interleaver write path. It accepts a frame of 8-bit data words from the upstream source over a valid/ready handshake and presents one registered word per accepted beat on the write port. For each word it asserts `count_enable` toward the eight `counter_wrapper2` address instances (offsets 0..7), so bit *i* of word *k* lands at address 8k+i. It also latches the block size, clears the address counters at frame start, and checks the declared frame length.

---
 rtl/interleaver_input_ctrl.sv | 160 ++++++++++++++++
 tb/tb_interleaver_input_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_input_ctrl.sv
// Frame-input controller for the interleaver write path.
// Accepts one frame of 8-bit words over valid/ready, re-issues each accepted
// word as a registered write beat, pulses the address-counter clear at frame
// start and flags frames whose in_last marker disagrees with the block size.
module interleaver_input_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       block_size_in,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       count_enable,
  output logic       counter_clear,
  output logic       block_size,
  output logic       busy,
  output logic       done,
  output logic       length_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Index of the final word: 132-word and 768-word frames.
  localparam logic [9:0] LAST_IDX_SMALL = 10'd131;
  localparam logic [9:0] LAST_IDX_LARGE = 10'd767;

  logic [2:0] state_q, state_d;
  logic [9:0] word_cnt_q, word_cnt_d;
  logic       block_size_q, block_size_d;
  logic       length_error_q, length_error_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       counter_clear_q, counter_clear_d;
  logic       done_q, done_d;

  logic [9:0] last_idx_s;
  logic       xfer_s;
  logic       final_s;

  // Handshake decode: a transfer can only happen while filling, independent of in_valid timing.
  always_comb begin
    last_idx_s = block_size_q ? LAST_IDX_LARGE : LAST_IDX_SMALL;
    xfer_s     = in_valid && (state_q == S_FILL);
    final_s    = xfer_s && (word_cnt_q == last_idx_s);
  end

  // Next-state, datapath and length-check logic.
  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    block_size_d   = block_size_q;
    length_error_d = length_error_q;
    wr_en_d        = 1'b0;
    wr_data_d      = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Size and error flag are owned by the new frame from here on;
          // the error flag stays visible after DONE until the next start.
          state_d        = S_LOAD;
          block_size_d   = block_size_in;
          length_error_d = 1'b0;
          word_cnt_d     = 10'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_FILL;
      end
      S_FILL: begin
        if (xfer_s) begin
          wr_en_d   = 1'b1;
          wr_data_d = in_data;
          // in_last is only checked, never obeyed: block size sets the length.
          if (in_last != final_s) begin
            length_error_d = 1'b1;
          end else begin
            length_error_d = length_error_q;
          end
          if (final_s) begin
            // Counter parks at zero so it never runs past the last index.
            word_cnt_d = 10'd0;
            state_d    = S_FLUSH;
          end else begin
            word_cnt_d = word_cnt_q + 10'd1;
            state_d    = S_FILL;
          end
        end else begin
          wr_en_d = 1'b0;
          state_d = S_FILL;
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next-state decode so they
    // line up exactly with the state they describe.
    in_ready_d      = (state_d == S_FILL);
    busy_d          = (state_d != S_IDLE);
    counter_clear_d = (state_d == S_LOAD);
    done_d          = (state_d == S_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      word_cnt_q      <= 10'd0;
      block_size_q    <= 1'b0;
      length_error_q  <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_data_q       <= 8'd0;
      in_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
      counter_clear_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      block_size_q    <= block_size_d;
      length_error_q  <= length_error_d;
      wr_en_q         <= wr_en_d;
      wr_data_q       <= wr_data_d;
      in_ready_q      <= in_ready_d;
      busy_q          <= busy_d;
      counter_clear_q <= counter_clear_d;
      done_q          <= done_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign wr_en         = wr_en_q;
  assign wr_data       = wr_data_q;
  assign count_enable  = wr_en_q;
  assign counter_clear = counter_clear_q;
  assign block_size    = block_size_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign length_error  = length_error_q;

endmodule

// File: tb/tb_interleaver_input_ctrl.sv
// Scoreboard bench for interleaver_input_ctrl: the driver pushes each issued
// word with the cycle it must appear on the write port; a monitor pops and
// compares on every falling edge.
module tb_interleaver_input_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       block_size_in;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       count_enable;
  logic       counter_clear;
  logic       block_size;
  logic       busy;
  logic       done;
  logic       length_error;

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t q[$];

  interleaver_input_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .block_size_in (block_size_in),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .count_enable  (count_enable),
    .counter_clear (counter_clear),
    .block_size    (block_size),
    .busy          (busy),
    .done          (done),
    .length_error  (length_error)
  );

  always #5 clk = ~clk;

  // cycle counter used to timestamp expected write beats
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: a write beat is expected exactly when the queue head is due now
  initial begin
    exp_t e;
    logic exp_w;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        exp_w = (q.size() > 0) && (q[0].c == cyc);
        chk("wr_en", wr_en, exp_w);
        chk("count_enable", count_enable, exp_w);
        if (exp_w) begin
          e = q.pop_front();
          chk("wr_data", wr_data, e.d);
          wr_cnt++;
        end
      end
    end
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, want finish before 400000");
    $fatal(1);
  end

  // One frame: sz size, in_last on word last_at (-1 = never), toggle valid,
  // reset after rst_after words (-1 = no reset), poke = start pulses while busy.
  task automatic run_frame(input logic sz, input int last_at, input bit toggle,
                           input int rst_after, input bit poke);
    int   n;
    int   k;
    int   c;
    int   tfin;
    int   w0;
    bit   err;
    exp_t e;
    n = sz ? 768 : 132;
    k = 0; c = 0; tfin = 0; err = 1'b0; w0 = wr_cnt;

    // cycle 0: start in IDLE
    start = 1'b1; block_size_in = sz; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", in_ready, 1'b0);
    step();
    start = 1'b0;
    // cycle 1: LOAD
    @(negedge clk);
    chk("load_clear", counter_clear, 1'b1);
    chk("load_ready", in_ready, 1'b0);
    chk("load_busy", busy, 1'b1);
    chk("load_lenerr", length_error, 1'b0);
    chk("load_bsize", block_size, sz);
    step();

    // FILL
    while (k < n) begin
      if (k == rst_after) begin
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_count_en", count_enable, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_clear", counter_clear, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bsize", block_size, 1'b0);
        chk("rst_lenerr", length_error, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        return;
      end
      in_valid = toggle ? ((c % 2) == 0) : 1'b1;
      in_data  = k[7:0];
      in_last  = (k == last_at);
      if (poke && (k == 10)) begin
        start = 1'b1; block_size_in = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk("fill_ready", in_ready, 1'b1);
      chk("fill_clear", counter_clear, 1'b0);
      chk("fill_bsize", block_size, sz);
      chk("fill_lenerr", length_error, err);
      chk("fill_done", done, 1'b0);
      if (in_valid) begin
        e.d = in_data;
        e.c = cyc + 1;
        q.push_back(e);
        if (in_last != (k == n - 1)) err = 1'b1;
        tfin = cyc;
        k++;
      end
      c++;
      step();
    end

    // FLUSH: valid held high must be ignored
    start = 1'b0; in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b0;
    @(negedge clk);
    chk("flush_ready", in_ready, 1'b0);
    chk("flush_busy", busy, 1'b1);
    chk("flush_done", done, 1'b0);
    chk("flush_lenerr", length_error, err);
    step();
    // DONE
    in_valid = 1'b0;
    if (poke) begin
      start = 1'b1; block_size_in = 1'b1;
    end
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("done_latency", cyc - tfin, 2);
    chk("done_ready", in_ready, 1'b0);
    chk("done_busy", busy, 1'b1);
    chk("done_lenerr", length_error, err);
    chk("done_bsize", block_size, sz);
    step();
    start = 1'b0;
    // back in IDLE
    @(negedge clk);
    chk("end_done", done, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("end_ready", in_ready, 1'b0);
    chk("end_clear", counter_clear, 1'b0);
    chk("end_lenerr", length_error, err);
    chk("end_bsize", block_size, sz);
    chk("wr_count", wr_cnt - w0, n);
    chk("queue_empty", q.size(), 0);
    step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; block_size_in = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", in_ready, 1'b0);
    chk("reset_wr_en", wr_en, 1'b0);
    chk("reset_wr_data", wr_data, 8'h00);
    chk("reset_clear", counter_clear, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_lenerr", length_error, 1'b0);
    chk("reset_bsize", block_size, 1'b0);
    reset = 1'b0;
    step();

    run_frame(1'b0, 131, 1'b0, -1, 1'b0);  // small, back-to-back
    run_frame(1'b1, 767, 1'b1, -1, 1'b0);  // large, valid toggling
    run_frame(1'b0, 50,  1'b0, -1, 1'b0);  // early in_last
    run_frame(1'b1, -1,  1'b0, -1, 1'b0);  // missing in_last; start clears flag
    run_frame(1'b0, 131, 1'b0, -1, 1'b1);  // start while busy and on DONE
    run_frame(1'b0, 131, 1'b0, 40, 1'b0);  // reset after 40 words
    run_frame(1'b0, 131, 1'b0, -1, 1'b0);  // full frame after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
